xor_crc_unit: RTL and testbench
===============================

// Module: xor_crc_unit
// PURPOSE
//  Parametrised CRC engine built on a multi-bit XOR (LFSR) network. Consumes DATA_W-bit beats
//  over a valid/ready stream, delimited by in_last. Emits one CRC word per frame on a
//  valid/ready result port. Sits between a byte/word source and framing/link logic.
// PARAMETERS
//  DATA_W   8        bits per input beat (>=1)
//  CRC_W    16       CRC register width (>=2)
//  POLY     16'h1021 generator polynomial, CRC_W bits; x^CRC_W term implicit
//  INIT     16'hFFFF CRC register value at frame start
//  XOR_OUT  16'h0000 XORed into register to form out_crc
//  RESIDUE  16'h0000 expected register value after data+appended CRC (check mode only)
// PORTS
//  clk        in   1       single clock; all logic on its rising edge
//  rst        in   1       reset, synchronous, active-high
//  in_valid   in   1       input beat valid
//  in_ready   out  1       engine accepts a beat this cycle
//  in_data    in   DATA_W  beat data, processed MSB first
//  in_last    in   1       beat is the final beat of the frame
//  out_valid  out  1       result valid
//  out_ready  in   1       sink accepts result
//  out_crc    out  CRC_W   final CRC (register ^ XOR_OUT)
//  out_err    out  1       register != RESIDUE at frame end (0 unless XOR_CRC_CHECK_EN)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset (clk edge with rst=1): state=IDLE, crc_q=INIT, out_valid=0, out_crc=0, out_err=0.
//    rst overrides all other inputs; a frame in flight is discarded, nothing is emitted.
//  - States: IDLE -> RUN on accepted beat with in_last=0; IDLE/RUN -> HOLD on accepted
//    beat with in_last=1; RUN stays RUN on accepted non-last beat; HOLD -> IDLE on
//    out_valid&&out_ready. No in_valid in RUN: stay RUN (gaps allowed, no timeout).
//  - in_ready = (state != HOLD) && !rst-cycle effects; combinational from state only.
//  - Accept = in_valid && in_ready. Per accept: crc_q <= step(crc_q, in_data), DATA_W serial
//    LFSR shifts unrolled into one cycle: for each bit b (MSB first): fb=crc[CRC_W-1]^b;
//    crc={crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
//  - Latency: out_valid rises the cycle after the last-beat accept; out_crc = step(...)^XOR_OUT
//    registered on that edge. Single-beat frames legal.
//  - HOLD: out_valid=1, out_crc/out_err stable, in_ready=0 until out_ready. On handshake:
//    out_valid=0, crc_q=INIT, state=IDLE; in_ready=1 the following cycle (one bubble per frame).
//  - in_data/in_last ignored when not accepted. out_ready ignored when out_valid=0.
//  - busy = 1 in RUN and HOLD.
// CONFIGURATION
//  XOR_CRC_CHECK_EN defined: on last-beat accept, out_err <= (step(crc_q,in_data) != RESIDUE),
//    held with out_crc; cleared on result handshake and reset.
//  Undefined: out_err tied 0; port kept so the interface is identical in both builds.
// STRUCTURE
//  xor_crc_pkg: state enum (IDLE, RUN, HOLD), default POLY/INIT constants, function crc_step.
//  Sub-module xor_crc_step: combinational DATA_W-deep XOR network (crc_in, data -> crc_out),
//  parametrised by DATA_W/CRC_W/POLY; xor_crc_unit holds FSM, registers and handshakes.
// TESTING
//  1. Defaults, frame "123456789" (0x31..0x39), out_ready=1 -> out_crc=0x29B1, 1 cycle after last.
//  2. Single beat 0x00, in_last=1 -> out_crc=0xE1F0; busy high exactly 1 cycle (HOLD).
//  3. Backpressure: test-1 frame, out_ready=0 for 5 cycles -> out_valid held, out_crc=0x29B1
//     stable, in_ready=0 throughout; in_valid offered during HOLD not consumed.
//  4. Reset mid-frame: send "1234", pulse rst 1 cycle, send "123456789" -> only one result,
//     0x29B1; out_valid never asserts for the aborted frame.
//  5. XOR_CRC_CHECK_EN: "123456789",0x29,0xB1 -> out_err=0; same with 0xB0 last -> out_err=1.
//  6. Back-to-back frames with random in_valid gaps -> results match reference model, in order.

Source files
------------

// File: rtl/xor_crc_pkg.sv
// Shared definitions for the xor_crc_unit codebase slice.
//   state_t            : engine FSM states (IDLE, RUN, HOLD)
//   XOR_CRC_DEF_POLY   : default generator polynomial (CRC-16/CCITT, x^16 implicit)
//   XOR_CRC_DEF_INIT   : default register value at frame start
//   crc_step()         : 16-bit CRC / 8-bit beat reference step, MSB first
package xor_crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [15:0] XOR_CRC_DEF_POLY = 16'h1021;
  localparam logic [15:0] XOR_CRC_DEF_INIT = 16'hFFFF;

  function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                           input logic [7:0]  data,
                                           input logic [15:0] poly);
    logic [15:0] r;
    logic        fb;
    r = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = r[15] ^ data[7 - i];
      r  = {r[14:0], 1'b0} ^ (fb ? poly : '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_crc_unit_step.sv
// Combinational CRC update: DATA_W serial LFSR shifts unrolled into one XOR network.
//   crc_in  [CRC_W]  : current register value
//   data    [DATA_W] : beat data, consumed MSB first
//   crc_out [CRC_W]  : register value after the whole beat
module xor_crc_step #(
  parameter int unsigned         DATA_W = 8,
  parameter int unsigned         CRC_W  = 16,
  parameter logic [CRC_W-1:0]    POLY   = CRC_W'(16'h1021)
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  logic [CRC_W-1:0] w_crc;
  logic             w_fb;

  always_comb begin
    w_crc = crc_in;
    w_fb  = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_fb  = w_crc[CRC_W-1] ^ data[DATA_W-1-i];
      w_crc = {w_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
    crc_out = w_crc;
  end

endmodule

// File: rtl/xor_crc_unit.sv
// Streaming CRC engine: DATA_W-bit beats in over valid/ready (framed by in_last),
// one CRC word out per frame over valid/ready.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input beat handshake; in_data MSB first, in_last ends frame
//   out_valid/out_ready   : result handshake; out_crc = register ^ XOR_OUT
//   out_err               : register != RESIDUE at frame end (check build only)
//   busy                  : engine is in RUN or HOLD
// Build option: define XOR_CRC_CHECK_EN to enable residue checking on out_err;
// otherwise out_err is constant 0 and the port is kept for interface parity.
module xor_crc_unit
  import xor_crc_pkg::*;
#(
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(XOR_CRC_DEF_POLY),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(XOR_CRC_DEF_INIT),
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic              out_err,
  output logic              busy
);

`ifdef XOR_CRC_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  state_t           r_state;
  logic [CRC_W-1:0] r_crc;
  logic             r_out_valid;
  logic [CRC_W-1:0] r_out_crc;
  logic             r_out_err;

  logic [CRC_W-1:0] w_crc_next;
  logic             w_accept;

  xor_crc_step #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) u_step (
    .crc_in  (r_crc),
    .data    (in_data),
    .crc_out (w_crc_next)
  );

  assign in_ready  = (r_state != HOLD);
  assign busy      = (r_state != IDLE);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_crc   = r_out_crc;
  assign out_err   = r_out_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_crc       <= INIT;
      r_out_valid <= 1'b0;
      r_out_crc   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (w_accept) begin
            r_crc <= w_crc_next;
            if (in_last) begin
              r_out_valid <= 1'b1;
              r_out_crc   <= w_crc_next ^ XOR_OUT;
              // CHECK_EN folds to 0 in the default build, leaving out_err constant.
              r_out_err   <= CHECK_EN && (w_crc_next != RESIDUE);
              r_state     <= HOLD;
            end else begin
              r_state     <= RUN;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_crc       <= INIT;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_crc_unit.sv
module tb_xor_crc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_crc;
  logic        out_err;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] sb_q[$];
  logic        sb_en    = 1'b0;
  logic        cnt_en   = 1'b0;
  int unsigned n_results = 0;
  logic        tx_done  = 1'b0;

  xor_crc_unit #(
    .DATA_W  (8),
    .CRC_W   (16),
    .POLY    (16'h1021),
    .INIT    (16'hFFFF),
    .XOR_OUT (16'h0000),
    .RESIDUE (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_crc   (out_crc),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference written independently of the DUT structure.
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r = c;
    for (int k = 7; k >= 0; k--) begin
      if (r[15] != d[k]) r = (r << 1) ^ 16'h1021;
      else               r = r << 1;
    end
    return r;
  endfunction

  // Presents one beat and returns after the edge where it is accepted.
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hXX;
    in_last  = 1'bX;
  endtask

  task automatic send_check_str(input logic l);
    for (int i = 0; i < 9; i++)
      send(8'h31 + 8'(i), (i == 8) ? l : 1'b0);
  endtask

  // Result monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (cnt_en) n_results++;
      if (sb_en) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", {16'b0, out_crc}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_crc", {16'b0, out_crc}, {16'b0, sb_q.pop_front()});
        end
      end
    end
  end

  initial begin
    logic [15:0] c;
    int          len;
    int          guard;
    logic [7:0]  b;

    // Reset state
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_crc",   {16'b0, out_crc},   32'd0);
    chk("rst_out_err",   {31'b0, out_err},   32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

    // 1: "123456789" -> 0x29B1, one cycle after the last beat
    out_ready = 1'b1;
    send_check_str(1'b1);
    chk("t1_valid",    {31'b0, out_valid}, 32'd1);
    chk("t1_crc",      {16'b0, out_crc},   32'h29B1);
    chk("t1_err",      {31'b0, out_err},   32'd0);
    chk("t1_in_ready", {31'b0, in_ready},  32'd0);
    @(posedge clk); #1;
    chk("t1_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("t1_idle",       {31'b0, busy},      32'd0);
    chk("t1_in_ready2",  {31'b0, in_ready},  32'd1);

    // 2: single beat 0x00 -> 0xE1F0, busy exactly one cycle
    send(8'h00, 1'b1);
    chk("t2_crc",  {16'b0, out_crc}, 32'hE1F0);
    chk("t2_busy", {31'b0, busy},    32'd1);
    @(posedge clk); #1;
    chk("t2_busy_off", {31'b0, busy}, 32'd0);

    // 3: backpressure for 5 cycles with a beat offered during HOLD
    out_ready = 1'b0;
    send_check_str(1'b1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid",    {31'b0, out_valid}, 32'd1);
      chk("t3_crc",      {16'b0, out_crc},   32'h29B1);
      chk("t3_in_ready", {31'b0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release", {31'b0, out_valid}, 32'd0);
    chk("t3_idle",    {31'b0, busy},      32'd0);

    // 4: reset mid-frame, then a full frame; only one result
    n_results = 0;
    cnt_en    = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 1'b0);
    chk("t4_busy_run", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_rst_busy",  {31'b0, busy},      32'd0);
    send_check_str(1'b1);
    chk("t4_crc", {16'b0, out_crc}, 32'h29B1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cnt_en = 1'b0;
    chk("t4_results", n_results, 32'd1);

`ifdef XOR_CRC_CHECK_EN
    // 5: residue check
    send_check_str(1'b0);
    send(8'h29, 1'b0);
    send(8'hB1, 1'b1);
    chk("t5_err_ok", {31'b0, out_err}, 32'd0);
    chk("t5_crc_ok", {16'b0, out_crc}, 32'h0000);
    @(posedge clk); #1;
    send_check_str(1'b0);
    send(8'h29, 1'b0);
    send(8'hB0, 1'b1);
    chk("t5_err_bad", {31'b0, out_err}, 32'd1);
    @(posedge clk); #1;
    chk("t5_err_clr", {31'b0, out_err}, 32'd0);
`else
    chk("t5_err_tied", {31'b0, out_err}, 32'd0);
`endif

    // 6: back-to-back random frames, random gaps and random out_ready
    sb_en = 1'b1;
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          len = $urandom_range(1, 5);
          c   = 16'hFFFF;
          for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            c = ref_crc(c, b);
            if (i == len - 1) sb_q.push_back(c);
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk); #1;
            end
            send(b, (i == len - 1));
          end
        end
        tx_done = 1'b1;
      end
      begin
        guard = 0;
        while ((!tx_done || sb_q.size() != 0) && guard < 3000) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
          guard++;
        end
        out_ready = 1'b1;
      end
    join
    @(posedge clk); #1;
    chk("t6_drain", sb_q.size(), 32'd0);
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
